input_synchronizer: RTL and testbench
=====================================

// Module: input_synchronizer
// PURPOSE
//   Brings the asynchronous board inputs into the system clock domain: reset, record and
//   play buttons plus clip-select switches 0/1. Front end of the record/playback controller.
//   q is the level-synchronized bundle; b carries one-cycle rising-edge pulses of the same bundle.
//   Also acts as the reset synchronizer: reset asserts asynchronously and releases synchronously.
// PARAMETERS
//   SYNC_STAGES      2  flop stages per bit; legal >= 2
//   DEBOUNCE_CYCLES  2  consecutive stable samples before a debounced bit updates (DEBOUNCE_EN only); legal >= 1
// PORTS
//   clock            in   1  system clock; all flops on rising edge
//   reset            in   1  async active-low reset (reset button); also sampled as q[4]
//   record           in   1  record button, async
//   play             in   1  play button, async
//   clipselectionwr  in   1  switch0, write clip select, async
//   clipselectionr   in   1  switch1, read clip select, async
//   q                out  5  synchronized levels {reset,record,play,clipselectionwr,clipselectionr}
//   b                out  5  rising-edge pulses of q, same bit order
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - reset==0 clears all sync, debounce, history and counter flops immediately, without waiting for a clock.
//     q=5'b0 and b=5'b0 while reset is low.
//   - Per bit: chain of SYNC_STAGES flops; q[i] = last stage. No logic between stages.
//   - Latency: an input level present at edge k appears on q at edge k+SYNC_STAGES-1.
//     With the default, q updates 2 edges after the input changes.
//   - q[4] is the reset synchronizer. Chain input is tied to 1; chain is cleared asynchronously by reset.
//     After reset rises, q[4] goes 1 after SYNC_STAGES edges.
//   - Edge history: q_d <= q each clock; reset value 0.
//   - b = q & ~q_d. Each 0->1 transition of q[i] gives exactly one clock of b[i]=1.
//   - Consequence: b[4] pulses once after every reset release.
//   - No pulse on 1->0 transitions; held-high inputs give no further pulses.
//   - All bits are independent with identical latency.
//   - Simultaneous input changes, e.g. a switch change together with a record press, stay aligned on q/b.
//     Consumers can therefore sample the clip select on the record/play pulse.
//   - Input pulses shorter than one clock period may be missed. Pulses of >= 1 period are guaranteed seen.
//   - Reset asserted mid-operation: outputs go to 0 at once. Pending edges are discarded and produce no pulse later.
// CONFIGURATION
//   DEBOUNCE_EN defined:
//     - Bits 3..0 pass through a filter after the sync chain; q[4] is never filtered.
//     - Filter: per-bit counter. The filtered value takes the synchronized value only after
//       DEBOUNCE_CYCLES consecutive clocks in which the synchronized value differs from the filtered value.
//     - Any sample equal to the filtered value clears the counter.
//     - Latency for bits 3..0 = SYNC_STAGES + DEBOUNCE_CYCLES edges.
//     - Glitches shorter than DEBOUNCE_CYCLES clocks are suppressed.
//     - b is derived from the filtered q.
//   DEBOUNCE_EN undefined: no counters are built; q is the raw sync-chain output.
// TESTING
//   1. reset=0 for 5 clocks, then 1 -> q=0,b=0 while low; q[4]=1 two edges after the release edge;
//      b[4]=1 for exactly one clock.
//   2. reset pulsed low mid-run for 5 clocks -> q and b clear asynchronously, before the next clock edge;
//      recovery as in scenario 1.
//   3. record=1 for 2 clocks with sw0=1, sw1=0 -> q=5'b11010 for 2 clocks, 2 edges late;
//      b[3]=1 for one clock; q[1]=1 from the same edge.
//   4. play=1 for 5 clocks with all four switch combos 00/01/10/11 in turn -> q[2] high for 5 clocks
//      each time; q[1:0] matches the switches; one b[2] pulse per press.
//   5. record held high for 100 clocks -> exactly one b[3] pulse; q[3] stays 1.
//   6. DEBOUNCE_EN, DEBOUNCE_CYCLES=2: 1-clock play glitch -> no change on q[2]/b[2];
//      3-clock press -> q[2]=1 at edge 4 after the rise, one b[2] pulse.

Source files
------------

// File: rtl/input_synchronizer.sv
// Brings the asynchronous board buttons and switches into the clock domain and doubles as the reset synchronizer.
// Optional per-bit debounce filter on bits 3..0 is built only when DEBOUNCE_EN is defined.
module input_synchronizer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       record,
    input  logic       play,
    input  logic       clipselectionwr,
    input  logic       clipselectionr,
    output logic [4:0] q,
    output logic [4:0] b
);

    // Bit 4 is the reset synchronizer: its chain input is tied high and only reset clears it.
    logic [4:0] raw_in;
    assign raw_in = {1'b1, record, play, clipselectionwr, clipselectionr};

    logic [SYNC_STAGES-1:0][4:0] sync_d, sync_q;
    logic [4:0]                  sync_out;
    logic [4:0]                  level;
    logic [4:0]                  hist_d, hist_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    end

    // NOTE: state flops use non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic [3:0]            filt_d, filt_q;
    logic [3:0][CNT_W-1:0] cnt_d, cnt_q;

    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync_out[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i] = sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = {sync_out[4], filt_q};
`else
    assign level = sync_out;
`endif

    always_comb begin
        hist_d = level;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Both terms clear asynchronously, so pulses in flight are dropped when reset asserts.
    assign q = level;
    assign b = level & ~hist_q;

endmodule

// File: tb/tb_input_synchronizer.sv
// Directed bench for input_synchronizer: a delay-line scoreboard of expected levels is
// pushed as stimulus is driven and popped once the synchronizer latency has elapsed.
module tb_input_synchronizer;

    localparam int SYNC = 2;
    localparam int DC   = 2;
`ifdef DEBOUNCE_EN
    localparam int LAT = SYNC + DC - 1;
`else
    localparam int LAT = SYNC - 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       record = 1'b0;
    logic       play = 1'b0;
    logic       clipselectionwr = 1'b0;
    logic       clipselectionr = 1'b0;
    logic [4:0] q;
    logic [4:0] b;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] sb[$];
    logic [4:0] prev_exp;
    int         b3_pulses;
    int         b2_pulses;

    input_synchronizer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .record         (record),
        .play           (play),
        .clipselectionwr(clipselectionwr),
        .clipselectionr (clipselectionr),
        .q              (q),
        .b              (b)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {record, play, clipselectionwr, clipselectionr} = v;
    endtask

    // Restart the scoreboard after a reset recovery; the chain holds zeros at that point.
    task automatic sb_start();
        sb.delete();
        for (int i = 0; i < LAT; i++) sb.push_back(4'b0000);
        prev_exp = 5'b10000;
    endtask

    // One clock: drive v, expect e to emerge LAT edges later on q[3:0].
    task automatic step(input string tag, input logic [3:0] v, input logic [3:0] e);
        logic [4:0] exp;
        drive(v);
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() > LAT) begin
            exp = {1'b1, sb.pop_front()};
            check5({tag, "_q"}, q, exp);
            check5({tag, "_b"}, b, exp & ~prev_exp);
            prev_exp = exp;
        end
        b3_pulses += int'(b[3]);
        b2_pulses += int'(b[2]);
    endtask

    task automatic reset_hold_and_release(input string tag);
        drive(4'b0000);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check5({tag, "_low_q"}, q, 5'b00000);
            check5({tag, "_low_b"}, b, 5'b00000);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i < SYNC; i++) begin
            @(posedge clock);
            #1;
            check5({tag, "_rel_q"}, q, 5'b00000);
            check5({tag, "_rel_b"}, b, 5'b00000);
        end
        @(posedge clock);
        #1;
        check5({tag, "_up_q"}, q, 5'b10000);
        check5({tag, "_up_b"}, b, 5'b10000);
        @(posedge clock);
        #1;
        check5({tag, "_after_q"}, q, 5'b10000);
        check5({tag, "_after_b"}, b, 5'b00000);
    endtask

    initial begin
        // Scenario 1: power-on reset asserts with no clock edge needed.
        #1 reset = 1'b0;
        #1;
        check5("por_async_q", q, 5'b00000);
        check5("por_async_b", b, 5'b00000);
        reset_hold_and_release("por");
        sb_start();
        for (int i = 0; i < 3; i++) step("idle", 4'b0000, 4'b0000);

        // Scenario 3: record with write-switch for two clocks.
        b3_pulses = 0;
        for (int i = 0; i < 2; i++) step("rec_sw", 4'b1010, 4'b1010);
        for (int i = 0; i < 4; i++) step("rec_sw_tail", 4'b0000, 4'b0000);
        check_int("rec_sw_b3_count", b3_pulses, 1);

        // Scenario 4: play pressed for five clocks with each switch combination.
        b2_pulses = 0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 5; i++) step("play_sw", {2'b01, 2'(c)}, {2'b01, 2'(c)});
            for (int i = 0; i < 3; i++) step("play_gap", 4'b0000, 4'b0000);
        end
        check_int("play_b2_count", b2_pulses, 4);

        // Scenario 5: record held for 100 clocks.
        b3_pulses = 0;
        for (int i = 0; i < 100; i++) step("rec_hold", 4'b1000, 4'b1000);
        for (int i = 0; i < 4; i++) step("rec_hold_tail", 4'b0000, 4'b0000);
        check_int("rec_hold_b3_count", b3_pulses, 1);

        // Scenario 2: reset mid-run with a play edge still inside the chain.
        for (int i = 0; i < 3; i++) step("pre_rst", 4'b1000, 4'b1000);
        drive(4'b1100);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check5("mid_async_q", q, 5'b00000);
        check5("mid_async_b", b, 5'b00000);
        reset_hold_and_release("mid");
        sb_start();
        b2_pulses = 0;
        for (int i = 0; i < 5; i++) step("post_rst", 4'b0000, 4'b0000);
        check_int("post_rst_no_b2", b2_pulses, 0);
        for (int i = 0; i < 2; i++) step("post_rst_sw", 4'b0001, 4'b0001);
        for (int i = 0; i < 4; i++) step("post_rst_tail", 4'b0000, 4'b0000);

`ifdef DEBOUNCE_EN
        // Scenario 6: single-clock glitch is filtered, three-clock press passes.
        b2_pulses = 0;
        step("glitch", 4'b0100, 4'b0000);
        for (int i = 0; i < 6; i++) step("glitch_tail", 4'b0000, 4'b0000);
        check_int("glitch_b2_count", b2_pulses, 0);
        for (int i = 0; i < 3; i++) step("press3", 4'b0100, 4'b0100);
        for (int i = 0; i < 6; i++) step("press3_tail", 4'b0000, 4'b0000);
        check_int("press3_b2_count", b2_pulses, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
